pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Generates a clean downstream reset from a PLL lock indicator. The raw
//   lock signal is synchronised into the PLL output clock domain. It must then
//   stay high for LOCK_STABLE_CYCLES consecutive cycles. After that, sys_reset
//   is held for RESET_HOLD_CYCLES more cycles before it is released. Any loss
//   of lock sends the sequencer back to waiting for lock, with no partial
//   credit. A soft reset request issued while running re-runs only the hold
//   phase.
//
// Parameters:
//   SYNC_STAGES        : synchroniser depth for locked (>= 2)
//   LOCK_STABLE_CYCLES : consecutive lock cycles needed to qualify (>= 1)
//   RESET_HOLD_CYCLES  : cycles sys_reset is held after qualification (>= 1)
//
// Ports:
//   clock_in        in   PLL output clock, the only clock of the block
//   reset           in   asynchronous active-high block reset
//   locked          in   PLL lock indicator (asynchronous to clock_in)
//   soft_reset      in   single-cycle request to re-run the reset hold
//   sys_reset       out  registered active-high downstream reset
//   ready           out  registered, high only in RUN
//   state           out  WAIT_LOCK=0, STABILIZE=1, HOLD_RESET=2, RUN=3
//   lock_loss_count out  saturating count of lock losses seen in RUN
//
// Configuration macro:
//   PLL_RESET_SEQ_LOSS_COUNTER_EN - when defined, builds the lock-loss
//   counter. When undefined, lock_loss_count is tied to zero.
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic       locked,
   input  logic       soft_reset,
   output logic       sys_reset,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] lock_loss_count
);

   localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK  = 2'd0,
      STABILIZE  = 2'd1,
      HOLD_RESET = 2'd2,
      RUN        = 2'd3
   } state_t;

   state_t                 cur_state;
   state_t                 next_state;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_next;
   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   locked_s;

   // Lock synchroniser; only the final stage is safe to use.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], locked};
      end
   end

   assign locked_s = sync_chain[SYNC_STAGES-1];

   // Next-state logic. The counter defaults to zero, so it clears on every
   // state change and only advances while a qualification phase continues.
   always_comb begin
      next_state = cur_state;
      cnt_next   = '0;
      case (cur_state)
         WAIT_LOCK: begin
            if (locked_s) next_state = STABILIZE;
         end
         STABILIZE: begin
            if (!locked_s)               next_state = WAIT_LOCK;
            else if (cnt == STABLE_LAST) next_state = HOLD_RESET;
            else                         cnt_next   = cnt + 1'b1;
         end
         HOLD_RESET: begin
            if (!locked_s)             next_state = WAIT_LOCK;
            else if (cnt == HOLD_LAST) next_state = RUN;
            else                       cnt_next   = cnt + 1'b1;
         end
         RUN: begin
            // Lock loss has priority over a simultaneous soft reset request.
            if (!locked_s)       next_state = WAIT_LOCK;
            else if (soft_reset) next_state = HOLD_RESET;
         end
         default: next_state = WAIT_LOCK;
      endcase
   end

   // sys_reset and ready are decoded from next_state so that both change on
   // the same edge as the state register.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         cur_state <= WAIT_LOCK;
         cnt       <= '0;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
      end else begin
         cur_state <= next_state;
         cnt       <= cnt_next;
         sys_reset <= (next_state != RUN);
         ready     <= (next_state == RUN);
      end
   end

   assign state = cur_state;

`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
   logic       lock_lost;
   logic [7:0] loss_cnt;

   assign lock_lost = (cur_state == RUN) && !locked_s;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         loss_cnt <= 8'd0;
      end else if (lock_lost && (loss_cnt != 8'hFF)) begin
         loss_cnt <= loss_cnt + 8'd1;
      end
   end

   assign lock_loss_count = loss_cnt;
`else
   assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Purpose:
//   Directed bench for pll_reset_sequencer with SYNC_STAGES=2,
//   LOCK_STABLE_CYCLES=8 and RESET_HOLD_CYCLES=4. The stimulus pushes the
//   expected state transitions (absolute edge number, state, loss count) into
//   a queue. A monitor pops one entry for every state change it observes and
//   checks the edge number, state, sys_reset, ready and lock_loss_count.
//   The expected loss count follows PLL_RESET_SEQ_LOSS_COUNTER_EN.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

   logic       clock_in = 1'b0;
   logic       reset = 1'b0;
   logic       locked = 1'b0;
   logic       soft_reset = 1'b0;
   logic       sys_reset;
   logic       ready;
   logic [1:0] state;
   logic [7:0] lock_loss_count;

   bit clk_en = 1'b1;
   int edge_cnt = 0;
   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   typedef struct {
      int edge_no;
      int st;
      int cnt;
   } exp_t;

   exp_t       q[$];
   logic [1:0] prev_state = 2'd0;

   pll_reset_sequencer #(
      .SYNC_STAGES       (2),
      .LOCK_STABLE_CYCLES(8),
      .RESET_HOLD_CYCLES (4)
   ) dut (
      .clock_in       (clock_in),
      .reset          (reset),
      .locked         (locked),
      .soft_reset     (soft_reset),
      .sys_reset      (sys_reset),
      .ready          (ready),
      .state          (state),
      .lock_loss_count(lock_loss_count)
   );

   always begin
      #5;
      if (clk_en) clock_in = ~clock_in;
   end

   always @(posedge clock_in) edge_cnt++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Monitor: each observed state change consumes one expected entry.
   always @(negedge clock_in) begin
      exp_t e;
      if (reset) begin
         prev_state = state;
      end else if (state != prev_state) begin
         if (q.size() == 0) begin
            chk("unexpected_state_change", int'(state), int'(prev_state));
         end else begin
            e = q.pop_front();
            chk("transition_edge", edge_cnt, e.edge_no);
            chk("state", int'(state), e.st);
            chk("sys_reset", int'(sys_reset), (e.st != 3) ? 1 : 0);
            chk("ready", int'(ready), (e.st == 3) ? 1 : 0);
            chk("lock_loss_count", int'(lock_loss_count), e.cnt);
         end
         prev_state = state;
      end
   end

   task automatic push(input int edge_no, input int st);
      exp_t e;
      e.edge_no = edge_no;
      e.st      = st;
      e.cnt     = model_cnt;
      q.push_back(e);
   endtask

   task automatic loss_inc();
`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
      if (model_cnt < 255) model_cnt++;
`endif
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   // Wait for the monitor to consume all expectations, within a cycle budget.
   task automatic drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge clock_in);
         #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout_pending", q.size(), 0);
         q.delete();
      end
   endtask

   // Full qualification from a first edge sampling locked=1 at base+1.
   task automatic push_qualify(input int base);
      push(base + 3, 1);
      push(base + 11, 2);
      push(base + 15, 3);
   endtask

   initial begin
      int base;

      // Reset state before any clock edge.
      #1 reset = 1'b1;
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_sys_reset", int'(sys_reset), 1);
      chk("rst_ready", int'(ready), 0);
      chk("rst_count", int'(lock_loss_count), 0);

      // Basic release with locked held high: RUN on edge 15.
      tick(2);
      reset = 1'b0;
      base = edge_cnt;
      locked = 1'b1;
      push_qualify(base);
      drain(30);

      // Lock glitch during qualification restarts from WAIT_LOCK.
      reset = 1'b1;
      model_cnt = 0;
      tick(2);
      reset = 1'b0;
      locked = 1'b0;
      tick(3);
      base = edge_cnt;
      locked = 1'b1;
      push(base + 3, 1);
      push(base + 8, 0);
      push_qualify(base + 8);
      tick(5);
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      drain(40);

      // Lock loss in RUN, then requalification.
      base = edge_cnt;
      locked = 1'b0;
      loss_inc();
      push(base + 3, 0);
      drain(10);
      base = edge_cnt;
      locked = 1'b1;
      push_qualify(base);
      drain(30);

      // Single-cycle soft reset in RUN: hold for 4 cycles only.
      base = edge_cnt;
      soft_reset = 1'b1;
      push(base + 1, 2);
      push(base + 5, 3);
      tick(1);
      soft_reset = 1'b0;
      drain(10);

      // Soft reset coincident with lock loss: lock loss wins.
      base = edge_cnt;
      locked = 1'b0;
      tick(2);
      soft_reset = 1'b1;
      loss_inc();
      push(base + 3, 0);
      tick(1);
      soft_reset = 1'b0;
      drain(10);

      // soft_reset is ignored outside RUN (WAIT_LOCK, STABILIZE, HOLD_RESET).
      soft_reset = 1'b1;
      tick(3);
      base = edge_cnt;
      locked = 1'b1;
      push_qualify(base);
      tick(14);
      soft_reset = 1'b0;
      drain(10);

      // Repeated lock losses: the counter saturates at 255.
      for (int i = 0; i < 256; i++) begin
         base = edge_cnt;
         locked = 1'b0;
         loss_inc();
         push(base + 3, 0);
         drain(10);
         base = edge_cnt;
         locked = 1'b1;
         push_qualify(base);
         drain(30);
      end
      chk("saturated_count", int'(lock_loss_count), model_cnt);

      // Reset in HOLD_RESET with the clock stopped acts immediately.
      reset = 1'b1;
      model_cnt = 0;
      tick(2);
      reset = 1'b0;
      base = edge_cnt;
      push(base + 3, 1);
      push(base + 11, 2);
      drain(30);
      tick(1);
      @(negedge clock_in);
      clk_en = 1'b0;
      #12;
      chk("hold_state_before_reset", int'(state), 2);
      reset = 1'b1;
      #1;
      chk("async_rst_state", int'(state), 0);
      chk("async_rst_sys_reset", int'(sys_reset), 1);
      chk("async_rst_ready", int'(ready), 0);
      chk("async_rst_count", int'(lock_loss_count), 0);
      clk_en = 1'b1;
      tick(2);
      reset = 1'b0;
      base = edge_cnt;
      push_qualify(base);
      drain(30);

      chk("queue_empty_at_end", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
